branch_predict_resolve: RTL
===========================

# branch_predict_resolve

Parametrised branch unit for the RISC-V pipeline: evaluates all six RV32I branch conditions in EX and provides a dynamic prediction to IF. Prediction uses a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB). The EX-stage resolution compares outcome and target against the prediction carried down the pipe. On a wrong prediction it drives a flush and a redirect PC to the hazard unit. Two performance counters record resolved branches and mispredictions.

## Interface
- XLEN, 32: operand/PC width.
- IDX_W, 6: table index width; 2^IDX_W entries.
- TAG_W, 8: BTB tag width; requires IDX_W+TAG_W+2 <= XLEN.
- CNT_INIT, 2'b01: counter reset value (weakly not-taken).
- PERF_W, 32: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- pc_f  in  XLEN  fetch PC.
- pred_taken_f  out  1  predicted taken.
- pred_target_f  out  XLEN  predicted target; 0 when not predicted taken.
- valid_e  in  1  EX holds a live instruction (not bubble, not flushed).
- stall_e  in  1  EX held this cycle; suppresses all state updates.
- branch_type_e  in  3  BranchType encoding.
- pc_e, operand1_e, operand2_e, target_e  in  XLEN  branch PC, rs1/rs2 (forwarded), computed target.
- pred_taken_e, pred_target_e  in  1/XLEN  prediction made for this instruction in IF.
- branch_e  out  1  actual outcome.
- mispredict_e  out  1  flush request.
- redirect_pc_e  out  XLEN  correct next PC.
- clr_perf  in  1  synchronous clear of performance counters.
- branch_cnt, mispredict_cnt  out  PERF_W  performance counters.

## Operation
- Conditions: BEQ ==, BNE !=, BLT signed <, BLTU unsigned <, BGE signed >=, BGEU unsigned >=. NOBRANCH and undefined codes give 0. BGE/BGEU are >=; equal operands are taken.
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Predict: pred_taken_f = btb_valid[idx] & btb_tag[idx]==tag & cnt[idx][1]. pred_target_f = btb_target[idx] when pred_taken_f, else 0.
- Resolution is active when valid_e & branch_type_e != NOBRANCH:
  - branch_e is the condition result.
  - mispredict_e = (branch_e != pred_taken_e) | (branch_e & pred_target_e != target_e).
  - redirect_pc_e = branch_e ? target_e : pc_e+4 (mod 2^XLEN).
- When resolution is inactive, branch_e, mispredict_e and redirect_pc_e are all 0.
- Update on a resolving edge (resolution active and !stall_e):
  - Counter at idx(pc_e): +1 saturating at 3 if taken, -1 saturating at 0 if not taken.
  - If taken: write BTB valid=1, tag, target_e at that index, overwriting any alias.
  - Not-taken never invalidates the BTB.
- Performance: branch_cnt +1 per resolving edge; mispredict_cnt +1 per resolving edge with mispredict_e. Both wrap modulo 2^PERF_W. clr_perf has priority: it zeroes both counters and drops the increment in the same edge.

## Timing
- branch_e, mispredict_e, redirect_pc_e, pred_* are combinational from inputs and registered tables; zero latency.
- Table updates become visible to pred_*_f on the cycle after the resolving edge.
- Same-cycle IF read and EX write of one index: IF sees the old entry; no bypass.
- A resolution held by stall_e updates state exactly once, on the edge where stall_e is low.
- Reset (async, any time, including mid-stall): all counters = CNT_INIT, all BTB valid = 0, performance counters = 0. Hence pred_taken_f = 0 and pred_target_f = 0 during and immediately after reset. Combinational EX outputs follow their inputs.

## Structure
- BranchType encodings (NOBRANCH 0, BEQ 1, BNE 2, BLT 3, BLTU 4, BGE 5, BGEU 6) stay in Parameters.v. The 2-bit counter constants are added there too.
- Sub-module branch_cond_eval: combinational condition evaluator, parametrised by XLEN.
- Top module holds the counter array, the BTB arrays, update logic and performance counters.

## Test plan
- Conditions: BGE with op1=op2=0x80000000 -> branch_e=1. BLTU with 0x00000001 vs 0xFFFFFFFF -> 1. BLT with the same operands -> 0. NOBRANCH with valid_e=1 -> branch_e=0, no update.
- Training: after reset, BEQ at pc_e=0x100 (target 0x140) taken 2x with pred_taken_e=0.
  - First resolve -> mispredict_e=1, redirect 0x140.
  - After the second: pc_f=0x100 -> pred_taken_f=1, pred_target_f=0x140.
- Saturation and fall-through: counter at 3, then not-taken resolve with pred_taken_e=1 -> mispredict_e=1, redirect_pc_e=0x104, counter 2, prediction stays taken.
- Target mismatch: pred_taken_e=1, pred_target_e=0x200, taken with target_e=0x240 -> mispredict_e=1, redirect 0x240, BTB target updated.
- Stall and clear: resolving instruction held 3 cycles by stall_e -> branch_cnt +1 only. clr_perf with a resolving mispredict on the same edge -> both counters 0.
- Async reset: assert rst_n low mid-stall between edges -> pred_taken_f=0 immediately, counters = CNT_INIT, performance counters 0.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared encodings for the branch unit: branch condition codes, 2-bit counter
// states and the saturating counter step.
package branch_predict_resolve_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_LTU  = 3'd4,
    BR_GE   = 3'd5,
    BR_GEU  = 3'd6
  } branch_type_t;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_cond_eval.sv
// Combinational evaluator for the six RV32I branch conditions; the
// no-branch code and unused codes evaluate to not-taken.
module branch_cond_eval
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (operand1 == operand2);
  assign lt_s = ($signed(operand1) < $signed(operand2));
  assign lt_u = (operand1 < operand2);

  always_comb begin
    taken = 1'b0;
    case (branch_type)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt_s;
      BR_LTU:  taken = lt_u;
      BR_GE:   taken = !lt_s;
      BR_GEU:  taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch unit: bimodal counters plus tagged BTB for IF prediction, EX-stage
// resolution with flush/redirect, and branch/mispredict performance counters.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = CNT_WNT,
  parameter int         PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pc_f,
  output logic              pred_taken_f,
  output logic [XLEN-1:0]   pred_target_f,
  input  logic              valid_e,
  input  logic              stall_e,
  input  logic [2:0]        branch_type_e,
  input  logic [XLEN-1:0]   pc_e,
  input  logic [XLEN-1:0]   operand1_e,
  input  logic [XLEN-1:0]   operand2_e,
  input  logic [XLEN-1:0]   target_e,
  input  logic              pred_taken_e,
  input  logic [XLEN-1:0]   pred_target_e,
  output logic              branch_e,
  output logic              mispredict_e,
  output logic [XLEN-1:0]   redirect_pc_e,
  input  logic              clr_perf,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]         cnt_reg        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid_reg;
  logic [TAG_W-1:0]   btb_tag_reg    [ENTRIES];
  logic [XLEN-1:0]    btb_target_reg [ENTRIES];
  logic [PERF_W-1:0]  branch_cnt_reg;
  logic [PERF_W-1:0]  mispredict_cnt_reg;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             cond_taken;
  logic             active;
  logic             update;
  logic             unused_pc_bits;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_e = pc_e[IDX_W+1:2];
  assign tag_e = pc_e[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{pc_f, pc_e};

  // Read is purely combinational: an EX write this cycle is seen by IF next cycle.
  assign pred_taken_f  = btb_valid_reg[idx_f] && (btb_tag_reg[idx_f] == tag_f) && cnt_reg[idx_f][1];
  assign pred_target_f = pred_taken_f ? btb_target_reg[idx_f] : '0;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .branch_type (branch_type_e),
    .operand1    (operand1_e),
    .operand2    (operand2_e),
    .taken       (cond_taken)
  );

  assign active        = valid_e && (branch_type_e != BR_NONE);
  assign branch_e      = active && cond_taken;
  assign mispredict_e  = active && ((branch_e != pred_taken_e) ||
                                    (branch_e && (pred_target_e != target_e)));
  assign redirect_pc_e = !active ? '0 : (branch_e ? target_e : pc_e + XLEN'(4));
  assign update        = active && !stall_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_reg[i] <= CNT_INIT;
      btb_valid_reg <= '0;
    end else if (update) begin
      cnt_reg[idx_e] <= cnt_step(cnt_reg[idx_e], branch_e);
      if (branch_e) btb_valid_reg[idx_e] <= 1'b1;
    end
  end

  // Tag/target need no reset: an entry is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (update && branch_e) begin
      btb_tag_reg[idx_e]    <= tag_e;
      btb_target_reg[idx_e] <= target_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (clr_perf) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (update) begin
      branch_cnt_reg <= branch_cnt_reg + PERF_W'(1);
      if (mispredict_e) mispredict_cnt_reg <= mispredict_cnt_reg + PERF_W'(1);
    end
  end

  assign branch_cnt     = branch_cnt_reg;
  assign mispredict_cnt = mispredict_cnt_reg;

endmodule
